// File: rtl/redtin_capture_readout_if.sv
// Bus bundle between the capture readout block and its neighbours:
// capture FSM handshake, capture RAM read port and UART TX byte port.
// master: the readout block itself. slave: the surrounding logic / RAM / UART.
interface redtin_capture_readout_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [7:0]            tx_data;
    logic                  tx_en;
    logic                  tx_busy;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, wr_ptr, rd_data, tx_busy,
        output rd_en, rd_addr, tx_data, tx_en, busy, done
    );

    modport slave (
        output start, wr_ptr, rd_data, tx_busy,
        input  rd_en, rd_addr, tx_data, tx_en, busy, done
    );
endinterface

// File: rtl/redtin_capture_readout.sv
// RedTin capture buffer reader: walks the circular sample RAM from the oldest
// sample (wr_ptr) to the newest, and streams every sample MSB byte first to
// the UART transmitter using a tx_en / tx_busy handshake.
// Optional: define REDTIN_READOUT_HEADER_EN to prefix the stream with a
// header of sync byte 0xA5 followed by DEPTH as two bytes, MSB first.
module redtin_capture_readout #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input logic                      clk,
    input logic                      rst_n,
    redtin_capture_readout_if.master bus
);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    // Byte counter also indexes the 3 header bytes, so never narrower than 2 bits.
    localparam int unsigned BCW = (NBYTES > 3) ? $clog2(NBYTES) : 2;
    localparam logic [BCW-1:0]        LAST_BYTE   = BCW'(NBYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_SAMPLE = ADDR_WIDTH'(DEPTH - 1);
`ifdef REDTIN_READOUT_HEADER_EN
    localparam logic [7:0]     SYNC_BYTE  = 8'hA5;
    localparam logic [15:0]    DEPTH_HDR  = 16'(DEPTH);
    localparam logic [BCW-1:0] LAST_HDR   = BCW'(2);
`endif

    typedef enum logic [2:0] {
        StIdle, StFetch, StWait, StLatch, StSend, StHold, StNext, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] scount_q, scount_d;
    logic [BCW-1:0]        bcount_q, bcount_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [7:0]            txd_q, txd_d;
    logic [7:0]            cur_byte;
    logic                  rd_en, tx_en;
`ifdef REDTIN_READOUT_HEADER_EN
    logic                  hdr_q, hdr_d;
`endif

    // Select the byte presented in SEND: header byte while in the header phase,
    // otherwise the top byte of the shift register.
    always_comb begin
        cur_byte = shreg_q[DATA_WIDTH-1 -: 8];
`ifdef REDTIN_READOUT_HEADER_EN
        if (hdr_q) begin
            unique case (bcount_q)
                BCW'(0): cur_byte = SYNC_BYTE;
                BCW'(1): cur_byte = DEPTH_HDR[15:8];
                default: cur_byte = DEPTH_HDR[7:0];
            endcase
        end
`endif
    end

    // Next-state logic and strobes for the readout FSM.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        scount_d = scount_q;
        bcount_d = bcount_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        rd_en    = 1'b0;
        tx_en    = 1'b0;
`ifdef REDTIN_READOUT_HEADER_EN
        hdr_d    = hdr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    base_d   = bus.wr_ptr;
                    scount_d = '0;
`ifdef REDTIN_READOUT_HEADER_EN
                    hdr_d    = 1'b1;
                    bcount_d = '0;
                    state_d  = StSend;
`else
                    state_d  = StFetch;
`endif
                end
            end
            StFetch: begin
                rd_en   = 1'b1;
                state_d = StWait;
            end
            StWait: state_d = StLatch;
            StLatch: begin
                shreg_d  = bus.rd_data;
                bcount_d = '0;
                state_d  = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    tx_en   = 1'b1;
                    txd_d   = cur_byte;
                    shreg_d = shreg_q << 8;
                    state_d = StHold;
                end
            end
            // Dead cycle: the TX raises tx_busy now, so it is not sampled here.
            StHold: begin
`ifdef REDTIN_READOUT_HEADER_EN
                if (hdr_q) begin
                    if (bcount_q == LAST_HDR) begin
                        hdr_d   = 1'b0;
                        state_d = StFetch;
                    end else begin
                        bcount_d = bcount_q + BCW'(1);
                        state_d  = StSend;
                    end
                end else
`endif
                if (bcount_q == LAST_BYTE) begin
                    state_d = StNext;
                end else begin
                    bcount_d = bcount_q + BCW'(1);
                    state_d  = StSend;
                end
            end
            StNext: begin
                if (scount_q == LAST_SAMPLE) begin
                    state_d = StDone;
                end else begin
                    scount_d = scount_q + ADDR_WIDTH'(1);
                    state_d  = StFetch;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any readout in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            base_q   <= '0;
            scount_q <= '0;
            bcount_q <= '0;
            shreg_q  <= '0;
            txd_q    <= '0;
`ifdef REDTIN_READOUT_HEADER_EN
            hdr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            scount_q <= scount_d;
            bcount_q <= bcount_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
`ifdef REDTIN_READOUT_HEADER_EN
            hdr_q    <= hdr_d;
`endif
        end
    end

    // Outputs: address wraps by natural truncation; tx_data shows the new byte
    // with the strobe and holds it afterwards.
    always_comb begin
        bus.rd_en   = rd_en;
        bus.rd_addr = base_q + scount_q;
        bus.tx_en   = tx_en;
        bus.tx_data = tx_en ? cur_byte : txd_q;
        bus.busy    = (state_q != StIdle);
        bus.done    = (state_q == StDone);
    end
endmodule

// File: doc/redtin_capture_readout.md
Name: redtin_capture_readout

Overview:
Reader side of the RedTin capture buffer. After the capture FSM finishes writing the circular sample RAM, this block reads every sample from oldest to newest. It splits each sample into bytes and hands them one at a time to the UART transmitter for upload to the host. It sits between the capture RAM read port and the UART TX in the analyzer top level.

Parameters:
DATA_WIDTH, 128, sample width in bits; must be a multiple of 8.
DEPTH, 512, capture RAM depth in samples; must be a power of two.
ADDR_WIDTH, 9, log2(DEPTH).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse from the capture FSM: capture complete.
wr_ptr  input  ADDR_WIDTH  capture write pointer at completion; this is the oldest sample.
rd_en  output  1  RAM read strobe.
rd_addr  output  ADDR_WIDTH  RAM read address.
rd_data  input  DATA_WIDTH  RAM read data, valid exactly 1 cycle after rd_en.
tx_data  output  8  byte to UART TX.
tx_en  output  1  one-cycle send strobe to UART TX.
tx_busy  input  1  UART TX busy; rises the cycle after tx_en and stays high until the byte is sent.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the last byte has been handed off.

Behaviour:
- Reset (async, rst_n=0): state IDLE. rd_en=0, rd_addr=0, tx_data=0, tx_en=0, busy=0, done=0. Sample counter, byte counter and shift register all clear.
- Reset mid-operation aborts immediately. No further tx_en is issued. RAM contents are untouched.
- States: IDLE, FETCH, WAIT, LATCH, SEND, HOLD, NEXT, DONE.
- IDLE: when start=1, latch base=wr_ptr, set scount=0, set busy=1, and go to FETCH.
- start is ignored in every state other than IDLE, including DONE.
- FETCH: for one cycle, rd_en=1 and rd_addr=(base+scount) mod DEPTH. Wrap uses natural ADDR_WIDTH truncation. Next state WAIT.
- WAIT: rd_en=0 and one cycle of RAM latency. Next state LATCH.
- LATCH: shift register <= rd_data. Set bcount=0. Next state SEND.
- SEND: wait until tx_busy=0. Then, for one cycle, tx_en=1 and tx_data=shreg[DATA_WIDTH-1 -: 8] (MSB byte first). Shift shreg left by 8 and go to HOLD.
- HOLD: one dead cycle so the TX can raise tx_busy; tx_busy is not sampled here. If bcount=DATA_WIDTH/8-1, go to NEXT. Otherwise bcount++ and go to SEND.
- NEXT: if scount=DEPTH-1, go to DONE. Otherwise scount++ and go to FETCH.
- DONE: done=1 for one cycle. busy=0 takes effect from the following cycle. Next state IDLE.
- tx_en is never high on two consecutive cycles. tx_en is never asserted while tx_busy=1.
- tx_data holds its last value between strobes.
- Total bytes per readout: DEPTH*DATA_WIDTH/8, plus the header when enabled.
- Sample order: wr_ptr, wr_ptr+1, … wrapping through DEPTH-1 to 0, ending at wr_ptr-1.
- wr_ptr=0 needs no wrap: order is 0..DEPTH-1.
- If tx_busy is stuck high, the block waits indefinitely in SEND. There is no timeout.

Optional Feature:
Macro: REDTIN_READOUT_HEADER_EN.
- Defined: after start is accepted, the block first sends sync byte 0xA5, then DEPTH as 2 bytes, MSB first. It then enters FETCH. The header uses the same SEND/HOLD handshake.
- Not defined: the block goes straight from IDLE to FETCH, and the byte stream contains sample data only.

Test Plan:
1. DATA_WIDTH=16, DEPTH=4, RAM={0x1111,0x2222,0x3333,0x4444}, wr_ptr=0, TX model busy 10 cycles per byte -> tx bytes 11,11,22,22,33,33,44,44; then one done pulse; busy low.
2. Same RAM, wr_ptr=2 -> rd_addr sequence 2,3,0,1; bytes 33,33,44,44,11,11,22,22.
3. Start pulses during readout, and a start pulse in the DONE cycle -> ignored; exactly 8 bytes and one done; the next start after IDLE produces a new 8-byte readout.
4. rst_n pulsed low for 1 cycle after the 3rd byte -> all outputs 0 asynchronously; no tx_en follows; a fresh start gives a full 8-byte readout.
5. TX model holding tx_busy high for 0 to 50 random cycles -> tx_en never high while tx_busy=1, never on consecutive cycles, and no bytes lost or duplicated.
6. REDTIN_READOUT_HEADER_EN defined, DEPTH=4 -> stream A5,00,04 followed by the 8 data bytes from test 1.
